// File: rtl/tensor_core_pkg.sv
// Shared element, matrix and state types for the tensor core loader.
package tensor_core_pkg;

    localparam int BUS_WIDTH = 8;

    typedef logic signed [BUS_WIDTH-1:0] int8_t;
    typedef int8_t mat4x4_t [4][4];

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/tensor_core_matrix_loader.sv
// Streams int8 bytes into a staging buffer of 4x4 matrices and
// commits the whole frame to the register file with a one-cycle strobe.
module tensor_core_matrix_loader
    import tensor_core_pkg::*;
#(
    parameter int NUMBER_OF_REGISTERS = 32,
    parameter int NUMBER_OF_MATRICES  = NUMBER_OF_REGISTERS / 16
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              stream_valid_in,
    input  logic signed [7:0] stream_data_in,
    input  logic              stream_last_in,
    output logic              stream_ready_out,
    output logic              bulk_write_enable_out,
    output logic signed [7:0] bulk_write_data_out [NUMBER_OF_MATRICES][4][4],
    output logic              short_frame_out,
    output logic [7:0]        commit_count_out
);

    localparam int CW = (NUMBER_OF_REGISTERS > 1) ?
                        $clog2(NUMBER_OF_REGISTERS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER_OF_REGISTERS - 1);

    ldr_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    mat4x4_t       buf_q [NUMBER_OF_MATRICES];
    mat4x4_t       buf_d [NUMBER_OF_MATRICES];
    logic          short_q, short_d;
    logic [7:0]    commits_q, commits_d;
    logic          run_q;
    logic          accept;
    logic          frame_end;
    logic          early;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        short_d   = short_q;
        commits_d = commits_q;

        // run_q keeps ready low until the first edge after reset release
        stream_ready_out = run_q && (state_q == FILL);
        accept    = stream_ready_out && stream_valid_in;
        frame_end = accept && (stream_last_in || count_q == LAST_IDX);
        early     = accept && stream_last_in && (count_q != LAST_IDX);

        case (state_q)
            FILL: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    for (int m = 0; m < NUMBER_OF_MATRICES; m++) begin
                        for (int r = 0; r < 4; r++) begin
                            for (int c = 0; c < 4; c++) begin
                                if (m * 16 + r * 4 + c == int'(count_q)) begin
                                    buf_d[m][r][c] = stream_data_in;
                                end else if (early &&
                                    m * 16 + r * 4 + c > int'(count_q)) begin
                                    buf_d[m][r][c] = '0;
                                end
                            end
                        end
                    end
                    if (frame_end) begin
                        state_d = COMMIT;
                        count_d = '0;
                        short_d = early;
                    end
                end
            end
            COMMIT: begin
                state_d   = FILL;
                commits_d = commits_q + 8'd1;
            end
        endcase
    end

    always_comb begin
        bulk_write_enable_out = (state_q == COMMIT);
        short_frame_out       = (state_q == COMMIT) && short_q;
        commit_count_out      = commits_q;
        for (int m = 0; m < NUMBER_OF_MATRICES; m++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    bulk_write_data_out[m][r][c] = buf_q[m][r][c];
                end
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= FILL;
            count_q   <= '0;
            short_q   <= 1'b0;
            commits_q <= '0;
            run_q     <= 1'b0;
            for (int m = 0; m < NUMBER_OF_MATRICES; m++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        buf_q[m][r][c] <= '0;
                    end
                end
            end
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            short_q   <= short_d;
            commits_q <= commits_d;
            run_q     <= 1'b1;
            buf_q     <= buf_d;
        end
    end

endmodule

// File: tb/tb_tensor_core_matrix_loader.sv
// Scoreboard bench for tensor_core_matrix_loader: frames are modelled
// as flat byte arrays and compared against each committed buffer.
module tb_tensor_core_matrix_loader;

    localparam int NR = 32;
    localparam int NM = NR / 16;

    typedef struct packed {
        logic [NR*8-1:0] d;
        logic            s;
    } frame_t;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              valid = 1'b0;
    logic signed [7:0] data  = '0;
    logic              last  = 1'b0;
    logic              ready;
    logic              en;
    logic              short_f;
    logic signed [7:0] wdata [NM][4][4];
    logic [7:0]        ccount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    int short_cnt = 0;
    int rdy_low  = 0;

    frame_t     exp_q[$];
    frame_t     obs_q[$];
    int         en_times[$];
    logic [7:0] mdl [NR];
    logic [7:0] fb  [NR];

    always #5 clk = ~clk;

    tensor_core_matrix_loader #(
        .NUMBER_OF_REGISTERS(NR)
    ) dut (
        .clock_in             (clk),
        .reset_in             (rst),
        .stream_valid_in      (valid),
        .stream_data_in       (data),
        .stream_last_in       (last),
        .stream_ready_out     (ready),
        .bulk_write_enable_out(en),
        .bulk_write_data_out  (wdata),
        .short_frame_out      (short_f),
        .commit_count_out     (ccount)
    );

    function automatic logic [NR*8-1:0] dut_flat();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i*8 +: 8] = wdata[i/16][(i%16)/4][i%4];
        end
        return v;
    endfunction

    function automatic logic [NR*8-1:0] mdl_flat();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) begin
            v[i*8 +: 8] = mdl[i];
        end
        return v;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && !ready) rdy_low++;
        if (short_f) short_cnt++;
        if (en) begin
            en_cnt++;
            en_times.push_back(cyc);
            obs_q.push_back(frame_t'({dut_flat(), short_f}));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        valid = 1'b1;
        data  = d;
        last  = l;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: ready=%b required=1", ready);
        end
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) mdl[i] = '0;
    endtask

    task automatic drive_frame(input int len, input int gap,
                               input bit use_last);
        for (int k = 0; k < len; k++) begin
            send(fb[k], use_last && (k == len - 1));
            mdl[k] = fb[k];
            if (gap > 0 && k < len - 1) repeat (gap) @(negedge clk);
        end
        for (int k = len; k < NR; k++) mdl[k] = '0;
        exp_q.push_back(frame_t'({mdl_flat(), len < NR}));
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int t = 0;
        while (obs_q.size() < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || en !== 1'b0 || short_f !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%b en=%b short=%b required=0 0 0",
                     ready, en, short_f);
        end
        checks++;
        if (ccount !== 8'd0) begin
            failures++;
            $display("FAIL reset_count: got=%0d required=0", ccount);
        end
        checks++;
        if (dut_flat() !== '0) begin
            failures++;
            $display("FAIL reset_buffer: got=%h required=0", dut_flat());
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready: got=%b required=0", ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_edge_ready: got=%b required=1", ready);
        end
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        int base;
        bit ok;
        frame_t o, e;
        do_reset();
        base = en_cnt;
        for (int k = 0; k < NR; k++) fb[k] = 8'(k + 1);
        drive_frame(NR, 0, 1'b1);
        wait_obs(1, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_timeout: commits=%0d required=1", obs_q.size());
            exp_q.delete();
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d) begin
                failures++;
                $display("FAIL full_data: got=%h required=%h", o.d, e.d);
            end
            checks++;
            if (o.s !== e.s) begin
                failures++;
                $display("FAIL full_short: got=%b required=%b", o.s, e.s);
            end
        end
        checks++;
        if (wdata[0][0][0] !== 8'sd1 || wdata[0][3][3] !== 8'sd16 ||
            wdata[1][0][0] !== 8'sd17 || wdata[1][3][3] !== 8'sd32) begin
            failures++;
            $display("FAIL full_layout: got=%0d %0d %0d %0d required=1 16 17 32",
                     wdata[0][0][0], wdata[0][3][3],
                     wdata[1][0][0], wdata[1][3][3]);
        end
        checks++;
        if (en_cnt - base !== 1) begin
            failures++;
            $display("FAIL full_pulses: got=%0d required=1", en_cnt - base);
        end
        checks++;
        if (ccount !== 8'd1) begin
            failures++;
            $display("FAIL full_count: got=%0d required=1", ccount);
        end
    endtask

    task automatic test_short_frame();
        int base;
        bit ok;
        frame_t o, e;
        base = short_cnt;
        for (int k = 0; k < 5; k++) fb[k] = 8'(-(k + 1));
        drive_frame(5, 0, 1'b1);
        wait_obs(1, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL short_timeout: commits=%0d required=1", obs_q.size());
            exp_q.delete();
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d) begin
                failures++;
                $display("FAIL short_data: got=%h required=%h", o.d, e.d);
            end
            checks++;
            if (o.s !== 1'b1) begin
                failures++;
                $display("FAIL short_flag: got=%b required=1", o.s);
            end
        end
        checks++;
        if (wdata[0][0][3] !== -8'sd4 || wdata[0][1][0] !== -8'sd5 ||
            wdata[1][3][3] !== 8'sd0) begin
            failures++;
            $display("FAIL short_layout: got=%0d %0d %0d required=-4 -5 0",
                     wdata[0][0][3], wdata[0][1][0], wdata[1][3][3]);
        end
        checks++;
        if (short_cnt - base !== 1) begin
            failures++;
            $display("FAIL short_pulse: got=%0d required=1", short_cnt - base);
        end
        checks++;
        if (ccount !== 8'd2) begin
            failures++;
            $display("FAIL short_count: got=%0d required=2", ccount);
        end
    endtask

    task automatic test_valid_toggle();
        int ebase, rbase;
        bit ok;
        frame_t o, e;
        ebase = en_cnt;
        rbase = rdy_low;
        for (int k = 0; k < NR; k++) begin
            if (k == NR - 1) begin
                checks++;
                if (en_cnt - ebase !== 0) begin
                    failures++;
                    $display("FAIL toggle_early_enable: got=%0d required=0",
                             en_cnt - ebase);
                end
            end
            send(8'h7F, 1'b0);
            mdl[k] = 8'h7F;
            if (k < NR - 1) @(negedge clk);
        end
        exp_q.push_back(frame_t'({mdl_flat(), 1'b0}));
        wait_obs(1, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL toggle_timeout: commits=%0d required=1", obs_q.size());
            exp_q.delete();
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d) begin
                failures++;
                $display("FAIL toggle_data: got=%h required=%h", o.d, e.d);
            end
        end
        checks++;
        if (rdy_low - rbase !== 1) begin
            failures++;
            $display("FAIL toggle_ready_low: got=%0d required=1", rdy_low - rbase);
        end
        checks++;
        if (en_cnt - ebase !== 1) begin
            failures++;
            $display("FAIL toggle_pulses: got=%0d required=1", en_cnt - ebase);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        bit ok;
        frame_t o, e;
        base = en_cnt;
        for (int k = 0; k < 10; k++) send(8'($urandom_range(1, 255)), 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0 || ready !== 1'b0 || ccount !== 8'd0) begin
            failures++;
            $display("FAIL midreset_outputs: en=%b rdy=%b cnt=%0d required=0 0 0",
                     en, ready, ccount);
        end
        checks++;
        if (dut_flat() !== '0) begin
            failures++;
            $display("FAIL midreset_buffer: got=%h required=0", dut_flat());
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (en_cnt - base !== 0 || obs_q.size() !== 0) begin
            failures++;
            $display("FAIL midreset_no_commit: pulses=%0d required=0",
                     en_cnt - base);
            obs_q.delete();
        end
        for (int k = 0; k < NR; k++) fb[k] = 8'($urandom_range(0, 255));
        drive_frame(NR, 0, 1'b0);
        wait_obs(1, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_timeout: commits=%0d required=1", obs_q.size());
            exp_q.delete();
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d || o.s !== e.s) begin
                failures++;
                $display("FAIL midreset_frame: got=%h/%b required=%h/%b",
                         o.d, o.s, e.d, e.s);
            end
        end
        checks++;
        if (ccount !== 8'd1) begin
            failures++;
            $display("FAIL midreset_count: got=%0d required=1", ccount);
        end
    endtask

    task automatic test_back_to_back();
        int tbase, ebase, bad;
        bit ok;
        frame_t o, e;
        do_reset();
        tbase = en_times.size();
        ebase = en_cnt;
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < NR; k++) fb[k] = 8'($urandom_range(0, 255));
            drive_frame(NR, 0, f[0]);
        end
        wait_obs(256, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout: commits=%0d required=256", obs_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d || o.s !== e.s) begin
                failures++;
                $display("FAIL b2b_frame: got=%h/%b required=%h/%b",
                         o.d, o.s, e.d, e.s);
            end
        end
        bad = 0;
        for (int i = tbase + 1; i < en_times.size(); i++) begin
            checks++;
            if (en_times[i] - en_times[i-1] !== 33) begin
                failures++;
                bad++;
                if (bad < 4)
                    $display("FAIL b2b_period: got=%0d required=33",
                             en_times[i] - en_times[i-1]);
            end
        end
        checks++;
        if (en_cnt - ebase !== 256) begin
            failures++;
            $display("FAIL b2b_pulses: got=%0d required=256", en_cnt - ebase);
        end
        checks++;
        if (ccount !== 8'd0) begin
            failures++;
            $display("FAIL b2b_wrap: got=%0d required=0", ccount);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            mdl[i] = '0;
            fb[i]  = '0;
        end
        test_reset();
        test_full_frame();
        test_short_frame();
        test_valid_toggle();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tensor_core_matrix_loader.md
TENSOR_CORE_MATRIX_LOADER -- requirements
Module: tensor_core_matrix_loader

Interface
REQ-001 SHALL have parameter NUMBER_OF_REGISTERS, default 32, total int8 entries per frame; multiple of 16.
REQ-002 SHALL have parameter NUMBER_OF_MATRICES, default NUMBER_OF_REGISTERS/16, 4x4 matrices per frame.
REQ-003 SHALL have port clock_in  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stream_valid_in  input  1  upstream byte valid.
REQ-006 SHALL have port stream_data_in  input  8 signed  upstream byte.
REQ-007 SHALL have port stream_last_in  input  1  marks final byte of a frame; qualified by valid.
REQ-008 SHALL have port stream_ready_out  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port bulk_write_enable_out  output  1  one-cycle commit strobe to register file bulk write enable.
REQ-010 SHALL have port bulk_write_data_out  output  8 signed x [NUMBER_OF_MATRICES][4][4]  staged frame.
REQ-011 SHALL have port short_frame_out  output  1  one-cycle pulse: committed frame ended early.
REQ-012 SHALL have port commit_count_out  output  8  number of commits since reset, wraps 255->0.

Function
REQ-013 SHALL implement states FILL and COMMIT only.
REQ-014 In FILL, stream_ready_out SHALL be 1; a byte is accepted when stream_valid_in and stream_ready_out are both 1 at a rising edge.
REQ-015 Accepted byte k (0-based, count within frame) SHALL be stored at [k/16][(k%16)/4][k%4].
REQ-016 Byte count SHALL increment by 1 per accepted byte, width $clog2(NUMBER_OF_REGISTERS).
REQ-017 FILL->COMMIT SHALL occur on acceptance of byte NUMBER_OF_REGISTERS-1, or on an accepted byte with stream_last_in=1, whichever first.
REQ-018 On early last (count < NUMBER_OF_REGISTERS-1), all entries after the last byte SHALL be zero-filled before the COMMIT cycle; short_frame_out SHALL be 1 during that COMMIT cycle.
REQ-019 stream_last_in on byte NUMBER_OF_REGISTERS-1 SHALL be a normal frame; no last at that byte SHALL also complete the frame normally.
REQ-020 In COMMIT, bulk_write_enable_out SHALL be 1 for exactly one cycle, stream_ready_out SHALL be 0, then state returns to FILL with count 0.
REQ-021 bulk_write_data_out SHALL be driven directly from the staging buffer and SHALL be stable throughout the COMMIT cycle (downstream samples on both clock edges).
REQ-022 Buffer contents SHALL persist after commit until overwritten; no clearing except zero-fill and reset.
REQ-023 commit_count_out SHALL increment on the rising edge that ends each COMMIT cycle.
REQ-024 Latency: byte accepted at edge N that completes a frame -> bulk_write_enable_out high during cycle N..N+1, low after edge N+1.
REQ-025 stream_valid_in during COMMIT SHALL be ignored; upstream holds data until ready.

Reset
REQ-026 reset_in=1 SHALL asynchronously force state FILL, count 0, buffer all zero, commit_count_out 0.
REQ-027 During reset: stream_ready_out 0, bulk_write_enable_out 0, short_frame_out 0; stream_ready_out rises on the first edge after deassertion.
REQ-028 Reset mid-frame or in COMMIT SHALL discard the partial frame and suppress any pending commit.

Structure
REQ-029 A shared package tensor_core_pkg SHALL hold BUS_WIDTH (8), the signed int8 element typedef, and the 4x4 matrix typedef.
REQ-030 No sub-module SHALL be instantiated; single always_ff plus combinational outputs.

Verification
REQ-031 32 bytes 1..32, valid always high, last on byte 32 -> single enable pulse, [0][0][0]=1, [0][3][3]=16, [1][0][0]=17, [1][3][3]=32, short_frame_out 0, count 1.
REQ-032 5 bytes -1,-2,-3,-4,-5 with last on 5th -> commit with [0][0][0..3]=-1..-4, [0][1][0]=-5, all others 0, short_frame_out 1.
REQ-033 valid toggled every other cycle for 32 bytes of 0x7F -> all entries 127, enable only after 32nd acceptance, ready 0 for exactly one cycle.
REQ-034 Reset asserted after byte 10 of a frame -> no enable pulse, buffer reads 0, next full frame of 32 bytes commits correctly.
REQ-035 256 back-to-back full frames -> commit_count_out wraps to 0, each frame exactly 33 cycles at full throughput.
